// File: rtl/vend_pkg.sv
// Shared types and input codes for the parametrised vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        VEND   = 2'd2,
        REFUND = 2'd3
    } state_t;

    localparam logic [1:0] DIN_NONE   = 2'b00;
    localparam logic [1:0] DIN_A      = 2'b01;
    localparam logic [1:0] DIN_B      = 2'b10;
    localparam logic [1:0] DIN_CANCEL = 2'b11;

endpackage

// File: rtl/vend_edge_det.sv
// Coin-slot event detector: a non-idle code counts once, only when it follows an idle cycle.
module vend_edge_det
    import vend_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] Din,
    output logic       coin_a_evt,
    output logic       coin_b_evt,
    output logic       cancel_evt
);

    logic [1:0] din_q;
    logic       evt;

    // Reset value 11 blocks any level held through reset until Din returns to idle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            din_q <= DIN_CANCEL;
        end else begin
            din_q <= Din;
        end
    end

    assign evt        = (Din != DIN_NONE) && (din_q == DIN_NONE);
    assign coin_a_evt = evt && (Din == DIN_A);
    assign coin_b_evt = evt && (Din == DIN_B);
    assign cancel_evt = evt && (Din == DIN_CANCEL);

endmodule

// File: rtl/vend_fsm_param.sv
// Vending controller: accumulates coin credit, dispenses at PRICE, returns change and refunds.
//
//   state  | meaning
//   IDLE   | no credit held
//   ACCUM  | 0 < credit < PRICE
//   VEND   | one-cycle dispense, Dout_0 high
//   REFUND | one-cycle refund of held credit
module vend_fsm_param
    import vend_pkg::*;
#(
    parameter int PRICE      = 3,
    parameter int COIN_A_VAL = 1,
    parameter int COIN_B_VAL = 2,
    parameter int CNT_W      = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [1:0]       Din,
    output logic             Dout,
    output logic             Dout_0,
    output logic [CNT_W-1:0] Change,
    output logic             Change_vld,
    output logic [CNT_W-1:0] Credit
);

    localparam int MAX_COIN = (COIN_A_VAL > COIN_B_VAL) ? COIN_A_VAL : COIN_B_VAL;

    if (PRICE < 1 || COIN_A_VAL < 1 || COIN_B_VAL < 1 ||
        (1 << CNT_W) <= (PRICE - 1 + MAX_COIN)) begin : g_param_check
        $error("vend_fsm_param: illegal parameter combination");
    end

    localparam logic [CNT_W:0]   PRICE_W  = (CNT_W+1)'(PRICE);
    localparam logic [CNT_W-1:0] PRICE_N  = CNT_W'(PRICE);
    localparam logic [CNT_W:0]   COIN_A_W = (CNT_W+1)'(COIN_A_VAL);
    localparam logic [CNT_W:0]   COIN_B_W = (CNT_W+1)'(COIN_B_VAL);

    state_t           state;
    logic [CNT_W-1:0] credit;
    logic             coin_a_evt;
    logic             coin_b_evt;
    logic             cancel_evt;
    logic             coin_evt;
    logic             vend_hit;
    logic [CNT_W:0]   coin_val;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] excess;

    vend_edge_det u_edge_det (
        .Clk        (Clk),
        .Reset      (Reset),
        .Din        (Din),
        .coin_a_evt (coin_a_evt),
        .coin_b_evt (coin_b_evt),
        .cancel_evt (cancel_evt)
    );

    always_comb begin
        coin_val = '0;
        if (coin_a_evt) begin
            coin_val = COIN_A_W;
        end else if (coin_b_evt) begin
            coin_val = COIN_B_W;
        end
    end

    assign coin_evt = coin_a_evt | coin_b_evt;
    assign sum      = {1'b0, credit} + coin_val;
    assign vend_hit = coin_evt && (sum >= PRICE_W);
    // sum never reaches 2^CNT_W, so the narrow subtraction is exact.
    assign excess   = sum[CNT_W-1:0] - PRICE_N;
    assign Dout     = vend_hit && !Reset;
    assign Credit   = credit;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            credit     <= '0;
            Dout_0     <= 1'b0;
            Change     <= '0;
            Change_vld <= 1'b0;
        end else begin
            Dout_0     <= 1'b0;
            Change_vld <= 1'b0;
            if (vend_hit) begin
                state  <= VEND;
                credit <= '0;
                Dout_0 <= 1'b1;
                if (excess != '0) begin
                    Change     <= excess;
                    Change_vld <= 1'b1;
                end
            end else if (coin_evt) begin
                state  <= ACCUM;
                credit <= sum[CNT_W-1:0];
            end else if (cancel_evt) begin
                if (credit != '0) begin
                    state      <= REFUND;
                    Change     <= credit;
                    Change_vld <= 1'b1;
                    credit     <= '0;
                end else begin
                    state <= IDLE;
                end
            end else if (state == VEND || state == REFUND) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_vend_fsm_param.sv
// Directed bench for vend_fsm_param with default parameters (PRICE=3, A=1, B=2, CNT_W=4).
module tb_vend_fsm_param;

    logic       Clk;
    logic       Reset;
    logic [1:0] Din;
    logic       Dout;
    logic       Dout_0;
    logic [3:0] Change;
    logic       Change_vld;
    logic [3:0] Credit;

    int errors = 0;
    int checks = 0;

    vend_fsm_param #(
        .PRICE      (3),
        .COIN_A_VAL (1),
        .COIN_B_VAL (2),
        .CNT_W      (4)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Din        (Din),
        .Dout       (Dout),
        .Dout_0     (Dout_0),
        .Change     (Change),
        .Change_vld (Change_vld),
        .Credit     (Credit)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic clk1();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] d);
        Din = d;
        #1;
    endtask

    task automatic idle2();
        drive(2'b00);
        clk1();
        clk1();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        Din   = 2'b00;
        clk1();
        chk("rst_credit", Credit, 0);
        chk("rst_dout", Dout, 0);
        chk("rst_dout0", Dout_0, 0);
        chk("rst_change", Change, 0);
        chk("rst_vld", Change_vld, 0);
        Reset = 1'b0;
        clk1();
        clk1();

        // three coin A
        drive(2'b01); chk("a1_dout", Dout, 0);
        clk1();       chk("a1_credit", Credit, 1);
        clk1();       idle2();
        drive(2'b01); chk("a2_dout", Dout, 0);
        clk1();       chk("a2_credit", Credit, 2);
        clk1();       idle2();
        drive(2'b01); chk("a3_dout", Dout, 1);
        clk1();
        chk("a3_dout0", Dout_0, 1);
        chk("a3_credit", Credit, 0);
        chk("a3_vld", Change_vld, 0);
        chk("a3_hold_dout", Dout, 0);
        clk1();       chk("a3_dout0_end", Dout_0, 0);
        idle2();

        // two coin B: dispense with change 1
        drive(2'b10); chk("b1_dout", Dout, 0);
        clk1();       chk("b1_credit", Credit, 2);
        clk1();       idle2();
        drive(2'b10); chk("b2_dout", Dout, 1);
        clk1();
        chk("b2_dout0", Dout_0, 1);
        chk("b2_change", Change, 1);
        chk("b2_vld", Change_vld, 1);
        chk("b2_credit", Credit, 0);
        clk1();
        chk("b2_vld_end", Change_vld, 0);
        chk("b2_dout0_end", Dout_0, 0);
        chk("b2_change_hold", Change, 1);
        idle2();

        // coin A then cancel
        drive(2'b01); clk1(); chk("c_credit", Credit, 1);
        idle2();
        drive(2'b11); chk("c_dout", Dout, 0);
        clk1();
        chk("c_change", Change, 1);
        chk("c_vld", Change_vld, 1);
        chk("c_credit0", Credit, 0);
        chk("c_dout0", Dout_0, 0);
        clk1();       chk("c_vld_end", Change_vld, 0);
        idle2();

        // B held six cycles counts once
        drive(2'b10);
        for (int i = 0; i < 6; i++) clk1();
        chk("hold_credit", Credit, 2);
        chk("hold_dout0", Dout_0, 0);
        idle2();
        drive(2'b11); clk1();
        chk("hold_refund", Change, 2);
        chk("hold_refund_vld", Change_vld, 1);
        idle2();

        // A directly to B without idle: B ignored
        drive(2'b01); clk1(); chk("ab_credit1", Credit, 1);
        drive(2'b10); chk("ab_dout", Dout, 0);
        clk1();       chk("ab_credit2", Credit, 1);
        clk1();       idle2();
        drive(2'b11); clk1(); chk("ab_refund", Change, 1);
        idle2();

        // A held through reset release
        Reset = 1'b1;
        drive(2'b01);
        clk1();
        Reset = 1'b0;
        clk1();
        clk1();       chk("rh_credit_held", Credit, 0);
        drive(2'b00); clk1(); chk("rh_credit_idle", Credit, 0);
        drive(2'b01); clk1(); chk("rh_credit_new", Credit, 1);
        idle2();
        drive(2'b11); clk1(); chk("rh_refund_vld", Change_vld, 1);
        idle2();

        // async reset mid-operation with credit 2
        drive(2'b10); clk1(); chk("ar_credit", Credit, 2);
        drive(2'b00);
        #1 Reset = 1'b1;
        #1;
        chk("ar_credit0", Credit, 0);
        chk("ar_dout", Dout, 0);
        chk("ar_dout0", Dout_0, 0);
        chk("ar_change", Change, 0);
        chk("ar_vld", Change_vld, 0);
        clk1();
        Reset = 1'b0;
        clk1();
        clk1();

        // cancel with zero credit
        drive(2'b11); clk1();
        chk("z_vld", Change_vld, 0);
        chk("z_change", Change, 0);
        chk("z_credit", Credit, 0);
        idle2();

        // coin right after VEND is processed from zero credit
        drive(2'b10); clk1(); chk("v_credit", Credit, 2);
        drive(2'b00); clk1();
        drive(2'b10); chk("v_dout", Dout, 1);
        clk1();
        chk("v_dout0", Dout_0, 1);
        chk("v_change", Change, 1);
        drive(2'b00); clk1();
        drive(2'b10); chk("v_next_dout", Dout, 0);
        clk1();       chk("v_next_credit", Credit, 2);
        chk("v_next_dout0", Dout_0, 0);
        idle2();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
